// File: rtl/morse_keyer.sv
// rtl/morse_keyer.sv - streaming ASCII to Morse key waveform encoder
module morse_keyer #(
  parameter int unsigned TICK_RATE = 5_000_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  output logic       key,
  output logic       char_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_MARK, S_ELEM_GAP, S_CHAR_GAP, S_GAP, S_ERR
  } state_t;

  localparam logic [31:0] TICK_LAST = 32'(TICK_RATE - 1);

  state_t      state_q, state_d;
  logic [31:0] cyc_q, cyc_d;
  logic [1:0]  unit_q, unit_d;
  logic [2:0]  elem_q, elem_d;
  logic [2:0]  len_q, len_d;
  logic [4:0]  bits_q, bits_d;
  logic        key_q, key_d;
  logic        err_q, err_d;

  // Returns {length, elements right-aligned}; length 0 marks an unsupported code.
  function automatic logic [7:0] lookup(input logic [7:0] c);
    case (c)
      "A": lookup = {3'd2, 5'b00001};
      "B": lookup = {3'd4, 5'b01000};
      "C": lookup = {3'd4, 5'b01010};
      "D": lookup = {3'd3, 5'b00100};
      "E": lookup = {3'd1, 5'b00000};
      "F": lookup = {3'd4, 5'b00010};
      "G": lookup = {3'd3, 5'b00110};
      "H": lookup = {3'd4, 5'b00000};
      "I": lookup = {3'd2, 5'b00000};
      "J": lookup = {3'd4, 5'b00111};
      "K": lookup = {3'd3, 5'b00101};
      "L": lookup = {3'd4, 5'b00100};
      "M": lookup = {3'd2, 5'b00011};
      "N": lookup = {3'd2, 5'b00010};
      "O": lookup = {3'd3, 5'b00111};
      "P": lookup = {3'd4, 5'b00110};
      "Q": lookup = {3'd4, 5'b01101};
      "R": lookup = {3'd3, 5'b00010};
      "S": lookup = {3'd3, 5'b00000};
      "T": lookup = {3'd1, 5'b00001};
      "U": lookup = {3'd3, 5'b00001};
      "V": lookup = {3'd4, 5'b00001};
      "W": lookup = {3'd3, 5'b00011};
      "X": lookup = {3'd4, 5'b01001};
      "Y": lookup = {3'd4, 5'b01011};
      "Z": lookup = {3'd4, 5'b01100};
      "0": lookup = {3'd5, 5'b11111};
      "1": lookup = {3'd5, 5'b01111};
      "2": lookup = {3'd5, 5'b00111};
      "3": lookup = {3'd5, 5'b00011};
      "4": lookup = {3'd5, 5'b00001};
      "5": lookup = {3'd5, 5'b00000};
      "6": lookup = {3'd5, 5'b10000};
      "7": lookup = {3'd5, 5'b11000};
      "8": lookup = {3'd5, 5'b11100};
      "9": lookup = {3'd5, 5'b11110};
      default: lookup = 8'd0;
    endcase
  endfunction

  logic       unit_done;
  logic [7:0] folded;
  logic [7:0] code;
  logic [1:0] mark_last;

  assign unit_done  = (cyc_q == TICK_LAST);
  assign folded     = (char_data >= "a" && char_data <= "z") ? char_data - 8'h20 : char_data;
  assign code       = lookup(folded);
  assign mark_last  = bits_q[4] ? 2'd2 : 2'd0;
  assign char_ready = (state_q == S_IDLE);
  assign key        = key_q;
  assign char_error = err_q;

  always_comb begin
    state_d = state_q;
    cyc_d   = unit_done ? 32'd0 : cyc_q + 32'd1;
    unit_d  = unit_done ? unit_q + 2'd1 : unit_q;
    elem_d  = elem_q;
    len_d   = len_q;
    bits_d  = bits_q;
    case (state_q)
      S_IDLE: begin
        cyc_d  = 32'd0;
        unit_d = 2'd0;
        if (char_valid) begin
          if (code[7:5] != 3'd0) begin
            state_d = S_MARK;
            len_d   = code[7:5];
            // Left-align so the current element is always bits_q[4].
            bits_d  = code[4:0] << (3'd5 - code[7:5]);
            elem_d  = 3'd0;
          end else if (char_data == 8'h20) begin
            state_d = S_GAP;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_MARK: begin
        if (unit_done && unit_q == mark_last) begin
          state_d = (elem_q == len_q - 3'd1) ? S_CHAR_GAP : S_ELEM_GAP;
          unit_d  = 2'd0;
        end
      end
      S_ELEM_GAP: begin
        if (unit_done) begin
          state_d = S_MARK;
          bits_d  = bits_q << 1;
          elem_d  = elem_q + 3'd1;
          unit_d  = 2'd0;
        end
      end
      S_CHAR_GAP: begin
        if (unit_done && unit_q == 2'd2) begin
          state_d = S_IDLE;
          unit_d  = 2'd0;
        end
      end
      S_GAP: begin
        if (unit_done && unit_q == 2'd3) begin
          state_d = S_IDLE;
          unit_d  = 2'd0;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
        cyc_d   = 32'd0;
        unit_d  = 2'd0;
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = 32'd0;
        unit_d  = 2'd0;
      end
    endcase
    key_d = (state_d == S_MARK);
    err_d = (state_d == S_ERR);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cyc_q   <= 32'd0;
      unit_q  <= 2'd0;
      elem_q  <= 3'd0;
      len_q   <= 3'd0;
      bits_q  <= 5'd0;
      key_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      unit_q  <= unit_d;
      elem_q  <= elem_d;
      len_q   <= len_d;
      bits_q  <= bits_d;
      key_q   <= key_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// tb/tb_morse_keyer.sv - directed table-driven bench for morse_keyer
module tb_morse_keyer;

  localparam int TR = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       char_ready;
  logic       key;
  logic       char_error;

  int checks = 0;
  int errors = 0;

  morse_keyer #(.TICK_RATE(TR)) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .key        (key),
    .char_error (char_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // pat holds the key level per unit, MSB-first over the low 'units' bits.
  typedef struct {
    logic [7:0]  ch;
    logic [31:0] pat;
    int          units;
    bit          hold;
  } vec_t;

  vec_t vecs[9];
  logic [7:0] bad_chars[8];

  task automatic run_char(input vec_t v);
    int bad;
    int first;
    logic exp_key;
    bad = 0;
    first = -1;
    @(negedge clk);
    check($sformatf("ready_before '%s'", v.ch), {31'd0, char_ready}, 32'd1);
    char_valid = 1'b1;
    char_data  = v.ch;
    @(posedge clk);
    #1;
    if (!v.hold) char_valid = 1'b0;
    for (int i = 0; i < v.units * TR; i++) begin
      @(negedge clk);
      exp_key = v.pat[v.units - 1 - i / TR];
      if (key !== exp_key || char_ready !== 1'b0 || char_error !== 1'b0) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    check($sformatf("wave '%s' first_bad_cycle=%0d bad_cycles", v.ch, first), bad, 32'd0);
  endtask

  task automatic run_err(input logic [7:0] c);
    @(negedge clk);
    check($sformatf("err_ready_before %0h", c), {31'd0, char_ready}, 32'd1);
    char_valid = 1'b1;
    char_data  = c;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    @(negedge clk);
    check($sformatf("err_pulse %0h {err,ready,key}", c), {29'd0, char_error, char_ready, key}, 32'b100);
    @(negedge clk);
    check($sformatf("err_after %0h {err,ready,key}", c), {29'd0, char_error, char_ready, key}, 32'b010);
  endtask

  initial begin
    int idle_bad;

    vecs[0] = '{ch: "A", pat: 32'b10111000,               units: 8,  hold: 1'b1};
    vecs[1] = '{ch: "a", pat: 32'b10111000,               units: 8,  hold: 1'b0};
    vecs[2] = '{ch: "E", pat: 32'b1000,                   units: 4,  hold: 1'b0};
    vecs[3] = '{ch: " ", pat: 32'b0000,                   units: 4,  hold: 1'b0};
    vecs[4] = '{ch: "E", pat: 32'b1000,                   units: 4,  hold: 1'b0};
    vecs[5] = '{ch: "0", pat: 32'b1110111011101110111000, units: 22, hold: 1'b0};
    vecs[6] = '{ch: "5", pat: 32'b101010101000,           units: 12, hold: 1'b0};
    vecs[7] = '{ch: "z", pat: 32'b11101110101000,         units: 14, hold: 1'b1};
    vecs[8] = '{ch: "T", pat: 32'b111000,                 units: 6,  hold: 1'b0};

    bad_chars[0] = 8'h23;
    bad_chars[1] = 8'h40;
    bad_chars[2] = 8'h5B;
    bad_chars[3] = 8'h60;
    bad_chars[4] = 8'h7B;
    bad_chars[5] = 8'h2F;
    bad_chars[6] = 8'h3A;
    bad_chars[7] = 8'h00;

    #2;
    check("reset {key,ready,err}", {29'd0, key, char_ready, char_error}, 32'b010);
    @(negedge clk);
    rst_n = 1'b1;

    idle_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (key !== 1'b0 || char_ready !== 1'b1 || char_error !== 1'b0) idle_bad++;
    end
    check("idle_50_cycles bad_cycles", idle_bad, 32'd0);

    for (int i = 0; i < 9; i++) run_char(vecs[i]);
    @(negedge clk);
    check("ready_after_table", {31'd0, char_ready}, 32'd1);

    for (int i = 0; i < 8; i++) run_err(bad_chars[i]);

    @(negedge clk);
    char_valid = 1'b1;
    char_data  = "T";
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_dah_key", {31'd0, key}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset {key,ready,err}", {29'd0, key, char_ready, char_error}, 32'b010);
    @(negedge clk);
    rst_n = 1'b1;
    run_char(vecs[8]);
    @(negedge clk);
    check("ready_after_reset_T", {31'd0, char_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
